inst_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the fetch-side sram-like master and the memory-side sram-like bus to the AXI bridge.

---
 rtl/inst_cache.sv | 160 ++++++++++++++++
 tb/tb_inst_cache.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: 2-cycle hits, line refill by single-word bus reads.
// Latency: hit data 1 cycle after accept; miss data 1 cycle after the last bus data. One fetch in flight; addr_ok only in IDLE.
module inst_cache #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  output logic        mem_inst_req,
  output logic        mem_inst_wr,
  output logic [1:0]  mem_inst_size,
  output logic [31:0] mem_inst_addr,
  output logic [31:0] mem_inst_wdata,
  input  logic        mem_inst_addr_ok,
  input  logic        mem_inst_data_ok,
  input  logic [31:0] mem_inst_rdata
);
  localparam int WORDS = 1 << (OFFSET_WIDTH - 2);
  localparam int CNT_W = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam int TAG_W = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MREQ, S_MWAIT, S_RESP} state_t;

  state_t                 r_state;
  logic [LINES-1:0]       r_valid;
  logic [TAG_W-1:0]       r_tag  [LINES];
  logic [31:0]            r_data [LINES][WORDS];
  logic [31:0]            r_addr;
  logic                   r_uncached;
  logic                   r_hit;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_data_ok;
  logic [31:0]            r_rdata;
  logic                   r_mem_req;
  logic [31:0]            r_mem_addr;

  logic [INDEX_WIDTH-1:0] w_in_index;
  logic [TAG_W-1:0]       w_in_tag;
  logic [CNT_W-1:0]       w_in_word;
  logic                   w_in_uncached;
  logic                   w_in_hit;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_W-1:0]       w_tag;
  logic [CNT_W-1:0]       w_word;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_last;
  logic [31:0]            w_line_base;
  logic                   w_unused;

  assign w_in_index    = cpu_inst_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign w_in_tag      = cpu_inst_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign w_in_word     = (OFFSET_WIDTH > 2) ? CNT_W'(cpu_inst_addr >> 2) : '0;
  assign w_in_uncached = (cpu_inst_addr[31:29] == 3'b101);
  assign w_in_hit      = r_valid[w_in_index] && (r_tag[w_in_index] == w_in_tag);

  assign w_index     = r_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign w_tag       = r_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign w_word      = (OFFSET_WIDTH > 2) ? CNT_W'(r_addr >> 2) : '0;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_last      = (r_cnt == CNT_W'(WORDS - 1));
  assign w_line_base = {r_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign w_unused    = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata};

  assign cpu_inst_addr_ok = (r_state == S_IDLE) && cpu_inst_req && !rst;
  assign cpu_inst_data_ok = r_data_ok;
  assign cpu_inst_rdata   = r_rdata;
  assign mem_inst_req     = r_mem_req;
  assign mem_inst_addr    = r_mem_addr;
  assign mem_inst_wr      = 1'b0;
  assign mem_inst_size    = 2'b10;
  assign mem_inst_wdata   = 32'd0;

  // Line storage is never reset; only the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (r_state == S_MWAIT && mem_inst_data_ok && !r_uncached)
      r_data[w_index][r_cnt] <= mem_inst_rdata;
    if (r_state == S_RESP && !r_uncached)
      r_tag[w_index] <= w_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_addr     <= 32'd0;
      r_uncached <= 1'b0;
      r_hit      <= 1'b0;
      r_cnt      <= '0;
      r_data_ok  <= 1'b0;
      r_rdata    <= 32'd0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_data_ok <= 1'b0;
          if (cpu_inst_req) begin
            // Lookup is resolved at accept so the hit response leaves a register.
            r_addr     <= cpu_inst_addr;
            r_uncached <= w_in_uncached;
            r_hit      <= w_in_hit && !w_in_uncached;
            r_data_ok  <= w_in_hit && !w_in_uncached;
            r_rdata    <= r_data[w_in_index][w_in_word];
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_data_ok <= 1'b0;
          if (r_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt      <= '0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_uncached ? r_addr : w_line_base;
            if (!r_uncached)
              r_valid[w_index] <= 1'b0;
            r_state    <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (mem_inst_addr_ok) begin
            r_mem_req <= 1'b0;
            r_state   <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (mem_inst_data_ok) begin
            if (r_uncached || w_last) begin
              r_data_ok <= 1'b1;
              r_rdata   <= (r_uncached || r_cnt == w_word) ? mem_inst_rdata
                                                           : r_data[w_index][w_word];
              r_state   <= S_RESP;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_line_base | (32'(w_cnt_nxt) << 2);
              r_state    <= S_MREQ;
            end
          end
        end
        S_RESP: begin
          r_data_ok <= 1'b0;
          if (!r_uncached)
            r_valid[w_index] <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache with a single-outstanding bus responder model.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_inst_req = 1'b0;
  logic        cpu_inst_wr = 1'b0;
  logic [1:0]  cpu_inst_size = 2'b10;
  logic [31:0] cpu_inst_addr = 32'd0;
  logic [31:0] cpu_inst_wdata = 32'd0;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic [31:0] cpu_inst_rdata;
  logic        mem_inst_req, mem_inst_wr;
  logic [1:0]  mem_inst_size;
  logic [31:0] mem_inst_addr, mem_inst_wdata;
  logic        mem_inst_addr_ok = 1'b0;
  logic        mem_inst_data_ok = 1'b0;
  logic [31:0] mem_inst_rdata = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = 0;

  logic [31:0] log_q[$];
  int stall_left = 0, stall_seen = 0, stall_bad = 0;
  logic [31:0] stall_addr = 32'd0;
  int dok_count = 0, last_dok_cyc = 0;
  bit pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  inst_cache dut (
    .clk(clk), .rst(rst),
    .cpu_inst_req(cpu_inst_req), .cpu_inst_wr(cpu_inst_wr), .cpu_inst_size(cpu_inst_size),
    .cpu_inst_addr(cpu_inst_addr), .cpu_inst_wdata(cpu_inst_wdata),
    .cpu_inst_addr_ok(cpu_inst_addr_ok), .cpu_inst_data_ok(cpu_inst_data_ok),
    .cpu_inst_rdata(cpu_inst_rdata),
    .mem_inst_req(mem_inst_req), .mem_inst_wr(mem_inst_wr), .mem_inst_size(mem_inst_size),
    .mem_inst_addr(mem_inst_addr), .mem_inst_wdata(mem_inst_wdata),
    .mem_inst_addr_ok(mem_inst_addr_ok), .mem_inst_data_ok(mem_inst_data_ok),
    .mem_inst_rdata(mem_inst_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h3C3C_F00F;
  endfunction

  // Bus model: accepts one request (after optional stall), returns data the next cycle.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_inst_addr_ok = 1'b0;
        mem_inst_data_ok = 1'b0;
        pend = 1'b0;
      end else begin
        mem_inst_data_ok = pend;
        if (pend) begin
          mem_inst_rdata = mem_val(pend_addr);
          dok_count++;
          last_dok_cyc = cyc;
        end
        pend = 1'b0;
        mem_inst_addr_ok = 1'b0;
        if (mem_inst_req) begin
          if (stall_left > 0) begin
            if (stall_seen == 0) stall_addr = mem_inst_addr;
            else if (mem_inst_addr !== stall_addr) stall_bad++;
            stall_left--;
            stall_seen++;
          end else begin
            mem_inst_addr_ok = 1'b1;
            pend = 1'b1;
            pend_addr = mem_inst_addr;
            log_q.push_back(mem_inst_addr);
          end
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                       output int acc_wait, output int lat);
    bit got;
    @(negedge clk);
    cpu_inst_req = 1'b1;
    cpu_inst_addr = a;
    #1;
    acc_wait = 0;
    while (!cpu_inst_addr_ok && acc_wait < 20) begin
      @(negedge clk); #1; acc_wait++;
    end
    @(posedge clk); #1;
    cpu_inst_req = 1'b0;
    lat = 0; got = 1'b0; d = 32'hxxxx_xxxx;
    while (!got && lat < 200) begin
      @(negedge clk); lat++;
      if (cpu_inst_data_ok) begin
        got = 1'b1; d = cpu_inst_rdata; done_cyc = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fetch_timeout addr=%h: no data_ok within %0d cycles", a, lat);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_inst_addr_ok, cpu_inst_data_ok, mem_inst_req, mem_inst_wr} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000",
                         {cpu_inst_addr_ok, cpu_inst_data_ok, mem_inst_req, mem_inst_wr});
    end
    checks++;
    if ({cpu_inst_rdata, mem_inst_addr, mem_inst_wdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data rdata=%h maddr=%h wdata=%h want 0",
                         cpu_inst_rdata, mem_inst_addr, mem_inst_wdata);
    end
    checks++;
    if (mem_inst_size !== 2'b10) begin
      errors++; $display("FAIL reset_size got=%b want=10", mem_inst_size);
    end
    rst = 1'b0;
  endtask

  task automatic test_uncached;
    logic [31:0] d; int aw, lat;
    for (int k = 0; k < 2; k++) begin
      log_q.delete();
      fetch(32'hBFC0_0000, d, aw, lat);
      checks++;
      if (log_q.size() != 1 || log_q[0] !== 32'hBFC0_0000) begin
        errors++; $display("FAIL uncached_req%0d n=%0d first=%h want 1 @bfc00000", k, log_q.size(), log_q[0]);
      end
      checks++;
      if (d !== mem_val(32'hBFC0_0000)) begin
        errors++; $display("FAIL uncached_data%0d got=%h want=%h", k, d, mem_val(32'hBFC0_0000));
      end
    end
  endtask

  task automatic test_miss;
    logic [31:0] d; int aw, lat;
    log_q.delete();
    fetch(32'h9FC0_0008, d, aw, lat);
    checks++;
    if (log_q.size() != 4) begin
      errors++; $display("FAIL miss_count got=%0d want=4", log_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q[i] !== 32'h9FC0_0000 + 32'(4 * i)) begin
        errors++; $display("FAIL miss_addr%0d got=%h want=%h", i, log_q[i], 32'h9FC0_0000 + 32'(4 * i));
      end
    end
    checks++;
    if (d !== mem_val(32'h9FC0_0008)) begin
      errors++; $display("FAIL miss_data got=%h want=%h", d, mem_val(32'h9FC0_0008));
    end
    checks++;
    if (done_cyc - last_dok_cyc != 1) begin
      errors++; $display("FAIL miss_latency got=%0d want=1", done_cyc - last_dok_cyc);
    end
  endtask

  task automatic test_hit(input logic [31:0] a, input string nm);
    logic [31:0] d; int aw, lat;
    log_q.delete();
    fetch(a, d, aw, lat);
    checks++;
    if (aw != 0 || lat != 1) begin
      errors++; $display("FAIL %s_timing accept_wait=%0d lat=%0d want 0/1", nm, aw, lat);
    end
    checks++;
    if (d !== mem_val(a)) begin
      errors++; $display("FAIL %s_data got=%h want=%h", nm, d, mem_val(a));
    end
    checks++;
    if (log_q.size() != 0) begin
      errors++; $display("FAIL %s_bus got=%0d reqs want=0", nm, log_q.size());
    end
  endtask

  task automatic test_refill(input logic [31:0] a, input string nm);
    logic [31:0] d; int aw, lat;
    log_q.delete();
    fetch(a, d, aw, lat);
    checks++;
    if (log_q.size() != 4 || log_q[0] !== {a[31:4], 4'h0} || log_q[3] !== {a[31:4], 4'hC}) begin
      errors++; $display("FAIL %s_reqs n=%0d first=%h last=%h want 4 from %h", nm,
                         log_q.size(), log_q[0], log_q[3], {a[31:4], 4'h0});
    end
    checks++;
    if (d !== mem_val(a)) begin
      errors++; $display("FAIL %s_data got=%h want=%h", nm, d, mem_val(a));
    end
  endtask

  task automatic test_stall;
    stall_seen = 0; stall_bad = 0; stall_left = 3;
    test_refill(32'h9FC0_0814, "stall");
    checks++;
    if (stall_seen != 3 || stall_bad != 0) begin
      errors++; $display("FAIL stall_hold seen=%0d unstable=%0d want 3/0", stall_seen, stall_bad);
    end
    checks++;
    if (stall_addr !== 32'h9FC0_0810) begin
      errors++; $display("FAIL stall_addr got=%h want=9fc00810", stall_addr);
    end
  endtask

  task automatic test_reset_refill;
    int n, base;
    log_q.delete();
    base = dok_count;
    @(negedge clk);
    cpu_inst_req = 1'b1; cpu_inst_addr = 32'h9FC0_0020;
    @(posedge clk); #1;
    cpu_inst_req = 1'b0;
    n = 0;
    while (dok_count < base + 2 && n < 100) begin @(posedge clk); n++; end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL rr_progress got=%0d bus words want=2", dok_count - base);
    end
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({cpu_inst_addr_ok, cpu_inst_data_ok, mem_inst_req} !== 3'b0 || mem_inst_addr !== 32'd0
        || cpu_inst_rdata !== 32'd0) begin
      errors++; $display("FAIL rr_outputs ctrl=%b maddr=%h rdata=%h want 0",
                         {cpu_inst_addr_ok, cpu_inst_data_ok, mem_inst_req}, mem_inst_addr, cpu_inst_rdata);
    end
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL rr_partial got=%0d reqs want=2", log_q.size());
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    test_refill(32'h9FC0_0020, "rr_refetch");
  endtask

  initial begin
    test_reset();
    test_uncached();
    test_miss();
    test_hit(32'h9FC0_000C, "hit");
    test_refill(32'h9FC0_0400, "conflict");
    test_refill(32'h9FC0_0000, "evicted");
    test_hit(32'h9FC0_0004, "hit_after_evict");
    test_stall();
    test_hit(32'h9FC0_081C, "hit_after_stall");
    test_reset_refill();
    test_hit(32'h9FC0_0028, "hit_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
